// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU memory path: access sizes, arbiter states and alignment rule.
package cpu_mem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_DONE   = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWNER_IF = 1'b0,
      OWNER_DM = 1'b1
   } arb_owner_e;

   // An access is bad if it is not naturally aligned for its size or uses the reserved size.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Winner select between fetch and data requests; data wins unless fetch has waited too long.
module ram_arb_pick
   import cpu_mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic             if_req,
   input  logic             dm_req,
   input  logic [CNT_W-1:0] starve_cnt,
   output logic             pick_if_c,
   output logic             pick_dm_c
);

   always_comb begin
      pick_dm_c = 1'b0;
      pick_if_c = 1'b0;
      if (dm_req && (!if_req || (starve_cnt < CNT_W'(STARVE_MAX)))) begin
         pick_dm_c = 1'b1;
      end else if (if_req) begin
         pick_if_c = 1'b1;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and data load/store, holding each
// access for MEM_LAT cycles and returning data with a one-cycle done pulse per requester.
module ram_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_err,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [1:0]        dm_size,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_done,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [1:0]        ram_size,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   arb_state_e        state_q, state_d;
   arb_owner_e        owner_q, owner_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [1:0]        ram_size_q, ram_size_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
   logic              if_done_q, if_done_d, dm_done_q, dm_done_d;
   logic              if_err_q, if_err_d, dm_err_q, dm_err_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic              busy_q, busy_d;
   logic              pick_if_c, pick_dm_c;
   logic              if_bad_c, dm_bad_c;

   ram_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_pick (
      .if_req     (if_req),
      .dm_req     (dm_req),
      .starve_cnt (starve_q),
      .pick_if_c  (pick_if_c),
      .pick_dm_c  (pick_dm_c)
   );

   assign if_bad_c = is_misaligned(SIZE_WORD, if_addr[1:0]);
   assign dm_bad_c = is_misaligned(dm_size, dm_addr[1:0]);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lat_d       = lat_q;
      starve_d    = starve_q;
      ram_en_d    = ram_en_q;
      ram_we_d    = ram_we_q;
      ram_size_d  = ram_size_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if_gnt_d    = 1'b0;
      dm_gnt_d    = 1'b0;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      if_err_d    = 1'b0;
      dm_err_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;

      case (state_q)
         ARB_IDLE: begin
            if (!if_req) begin
               starve_d = '0;
            end
            if (pick_dm_c) begin
               owner_d  = OWNER_DM;
               dm_gnt_d = 1'b1;
               if (if_req && (starve_q != CNT_W'(STARVE_MAX))) begin
                  starve_d = starve_q + CNT_W'(1);
               end
               if (dm_bad_c) begin
                  // Rejected before reaching RAM: report immediately.
                  dm_done_d  = 1'b1;
                  dm_err_d   = 1'b1;
                  dm_rdata_d = '0;
                  state_d    = ARB_DONE;
               end else begin
                  ram_en_d    = 1'b1;
                  ram_we_d    = dm_we;
                  ram_size_d  = dm_size;
                  ram_addr_d  = dm_addr;
                  ram_wdata_d = dm_wdata;
                  lat_d       = LAT_W'(MEM_LAT - 1);
                  state_d     = ARB_ACCESS;
               end
            end else if (pick_if_c) begin
               owner_d  = OWNER_IF;
               if_gnt_d = 1'b1;
               starve_d = '0;
               if (if_bad_c) begin
                  if_done_d  = 1'b1;
                  if_err_d   = 1'b1;
                  if_rdata_d = '0;
                  state_d    = ARB_DONE;
               end else begin
                  ram_en_d    = 1'b1;
                  ram_we_d    = 1'b0;
                  ram_size_d  = SIZE_WORD;
                  ram_addr_d  = if_addr;
                  ram_wdata_d = '0;
                  lat_d       = LAT_W'(MEM_LAT - 1);
                  state_d     = ARB_ACCESS;
               end
            end
         end

         ARB_ACCESS: begin
            if (lat_q == '0) begin
               ram_en_d = 1'b0;
               state_d  = ARB_DONE;
               if (owner_q == OWNER_DM) begin
                  dm_done_d = 1'b1;
                  if (!ram_we_q) begin
                     dm_rdata_d = ram_rdata;
                  end
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = ram_rdata;
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end

         ARB_DONE: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      busy_d = (state_d != ARB_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         owner_q     <= OWNER_IF;
         lat_q       <= '0;
         starve_q    <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_size_q  <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_gnt_q    <= 1'b0;
         dm_gnt_q    <= 1'b0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         if_err_q    <= 1'b0;
         dm_err_q    <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         lat_q       <= lat_d;
         starve_q    <= starve_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_size_q  <= ram_size_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         if_gnt_q    <= if_gnt_d;
         dm_gnt_q    <= dm_gnt_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         if_err_q    <= if_err_d;
         dm_err_q    <= dm_err_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_gnt    = if_gnt_q;
   assign if_done   = if_done_q;
   assign if_rdata  = if_rdata_q;
   assign if_err    = if_err_q;
   assign dm_gnt    = dm_gnt_q;
   assign dm_done   = dm_done_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_err    = dm_err_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_size  = ram_size_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: drivers push expected responses from a byte-level
// memory model, a monitor pops and compares on every done pulse and checks grant ordering.
module tb_ram_port_arbiter;
   import cpu_mem_pkg::*;

   localparam int unsigned ADDR_W     = 9;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned MEM_LAT    = 2;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned MEM_BYTES  = 512;
   localparam int unsigned WAIT_MAX   = 200;

   typedef struct {
      logic              we;
      logic [1:0]        size;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int unsigned       gap;
   } stim_t;

   typedef struct {
      logic              err;
      logic [DATA_W-1:0] rdata;
      int unsigned       lat;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req, if_gnt, if_done, if_err;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req, dm_we, dm_gnt, dm_done, dm_err;
   logic [1:0]        dm_size;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata, dm_rdata;
   logic              ram_en, ram_we, busy;
   logic [1:0]        ram_size;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   logic [7:0]        ram_mem [MEM_BYTES];
   logic [7:0]        ref_mem [MEM_BYTES];
   stim_t             dm_stim[$], if_stim[$];
   exp_t              dm_q[$], if_q[$];
   logic [DATA_W-1:0] dm_last, if_last;
   int unsigned       n_vec, n_err;
   int unsigned       cyc, dm_gcyc, if_gcyc, dm_dcyc, dm_en, if_en, dm_while_if;
   bit                acc_open, owner_dm;
   bit                gnt_log[$];

   always #5 clk = ~clk;

   ram_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
      .if_rdata(if_rdata), .if_err(if_err),
      .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
      .dm_err(dm_err),
      .ram_en(ram_en), .ram_we(ram_we), .ram_size(ram_size), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
   );

   // Big-endian byte-addressed RAM behind the arbiter.
   always_comb begin
      case (ram_size)
         2'b00:   ram_rdata = {24'h0, ram_mem[ram_addr]};
         2'b01:   ram_rdata = {16'h0, ram_mem[ram_addr], ram_mem[ram_addr + 9'd1]};
         default: ram_rdata = {ram_mem[ram_addr], ram_mem[ram_addr + 9'd1],
                               ram_mem[ram_addr + 9'd2], ram_mem[ram_addr + 9'd3]};
      endcase
   end

   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         case (ram_size)
            2'b00: ram_mem[ram_addr] <= ram_wdata[7:0];
            2'b01: begin
               ram_mem[ram_addr]        <= ram_wdata[15:8];
               ram_mem[ram_addr + 9'd1] <= ram_wdata[7:0];
            end
            default: begin
               ram_mem[ram_addr]        <= ram_wdata[31:24];
               ram_mem[ram_addr + 9'd1] <= ram_wdata[23:16];
               ram_mem[ram_addr + 9'd2] <= ram_wdata[15:8];
               ram_mem[ram_addr + 9'd3] <= ram_wdata[7:0];
            end
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: most significant byte at the lowest address.
   task automatic ref_write(input logic [1:0] size, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
      int nb;
      nb = 1 << size;
      for (int k = 0; k < nb; k++)
         ref_mem[(int'(a) + k) % MEM_BYTES] = 8'(d >> (8 * (nb - 1 - k)));
   endtask

   task automatic ref_read(input logic [1:0] size, input logic [ADDR_W-1:0] a,
                           output logic [DATA_W-1:0] d);
      int nb;
      nb = 1 << size;
      d  = '0;
      for (int k = 0; k < nb; k++)
         d = (d << 8) | DATA_W'(ref_mem[(int'(a) + k) % MEM_BYTES]);
   endtask

   task automatic dm_expect(input stim_t s, output exp_t e);
      bit bad;
      bad = (s.size == 2'd3) || (s.size == 2'd1 && (int'(s.addr) % 2) != 0) ||
            (s.size == 2'd2 && (int'(s.addr) % 4) != 0);
      if (bad) begin
         e.err = 1'b1; e.lat = 0; dm_last = '0;
      end else begin
         e.err = 1'b0; e.lat = MEM_LAT;
         if (s.we) ref_write(s.size, s.addr, s.wdata);
         else      ref_read(s.size, s.addr, dm_last);
      end
      e.rdata = dm_last;
   endtask

   task automatic if_expect(input stim_t s, output exp_t e);
      if ((int'(s.addr) % 4) != 0) begin
         e.err = 1'b1; e.lat = 0; if_last = '0;
      end else begin
         e.err = 1'b0; e.lat = MEM_LAT;
         ref_read(2'd2, s.addr, if_last);
      end
      e.rdata = if_last;
   endtask

   task automatic push_dm(input logic we, input logic [1:0] size, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int unsigned gap);
      stim_t s;
      s.we = we; s.size = size; s.addr = a; s.wdata = d; s.gap = gap;
      dm_stim.push_back(s);
   endtask

   task automatic push_if(input logic [ADDR_W-1:0] a, input int unsigned gap);
      stim_t s;
      s.we = 1'b0; s.size = SIZE_WORD; s.addr = a; s.wdata = '0; s.gap = gap;
      if_stim.push_back(s);
   endtask

   task automatic run_dm();
      stim_t s; exp_t e; int unsigned w;
      while (dm_stim.size() != 0) begin
         s = dm_stim.pop_front();
         @(negedge clk);
         if (s.gap != 0) begin
            dm_req = 1'b0;
            repeat (s.gap) @(negedge clk);
         end
         dm_we = s.we; dm_size = s.size; dm_addr = s.addr; dm_wdata = s.wdata; dm_req = 1'b1;
         dm_expect(s, e);
         dm_q.push_back(e);
         w = 0;
         do begin @(posedge clk); #1; w++; end while (!dm_done && w < WAIT_MAX);
         chk("dm_done_seen", 32'(dm_done), 32'd1);
      end
      @(negedge clk);
      dm_req = 1'b0;
   endtask

   task automatic run_if();
      stim_t s; exp_t e; int unsigned w;
      while (if_stim.size() != 0) begin
         s = if_stim.pop_front();
         @(negedge clk);
         if (s.gap != 0) begin
            if_req = 1'b0;
            repeat (s.gap) @(negedge clk);
         end
         if_addr = s.addr; if_req = 1'b1;
         if_expect(s, e);
         if_q.push_back(e);
         w = 0;
         do begin @(posedge clk); #1; w++; end while (!if_done && w < WAIT_MAX);
         chk("if_done_seen", 32'(if_done), 32'd1);
      end
      @(negedge clk);
      if_req = 1'b0;
   endtask

   // Monitor: grant bookkeeping and scoreboard pops on done pulses.
   always begin
      exp_t e;
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
         acc_open = 1'b0; dm_while_if = 0; dm_en = 0; if_en = 0;
      end else begin
         if (!if_req) dm_while_if = 0;
         if (dm_gnt || if_gnt) begin
            chk("single_grant", 32'(dm_gnt && if_gnt), 32'd0);
            chk("no_overlap", 32'(acc_open), 32'd0);
            acc_open = 1'b1;
            owner_dm = dm_gnt;
            gnt_log.push_back(dm_gnt);
         end
         if (dm_gnt) begin
            dm_gcyc = cyc; dm_en = 0;
            if (if_req) begin
               dm_while_if++;
               chk("starve_bound", 32'(dm_while_if <= STARVE_MAX), 32'd1);
            end
         end
         if (if_gnt) begin
            if_gcyc = cyc; if_en = 0; dm_while_if = 0;
         end
         if (ram_en) begin
            if (owner_dm) dm_en++;
            else          if_en++;
         end
         if (dm_done) begin
            acc_open = 1'b0; dm_dcyc = cyc;
            chk("dm_done_expected", 32'(dm_q.size() != 0), 32'd1);
            if (dm_q.size() != 0) begin
               e = dm_q.pop_front();
               chk("dm_err", 32'(dm_err), 32'(e.err));
               chk("dm_rdata", dm_rdata, e.rdata);
               chk("dm_latency", 32'(cyc - dm_gcyc), 32'(e.lat));
               chk("dm_ram_en_cycles", 32'(dm_en), 32'(e.lat));
            end
         end
         if (if_done) begin
            acc_open = 1'b0;
            chk("if_done_expected", 32'(if_q.size() != 0), 32'd1);
            if (if_q.size() != 0) begin
               e = if_q.pop_front();
               chk("if_err", 32'(if_err), 32'(e.err));
               chk("if_rdata", if_rdata, e.rdata);
               chk("if_latency", 32'(cyc - if_gcyc), 32'(e.lat));
               chk("if_ram_en_cycles", 32'(if_en), 32'(e.lat));
            end
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; dm_last = '0; if_last = '0;
      acc_open = 1'b0; owner_dm = 1'b0; dm_while_if = 0;
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
         ram_mem[i] = 8'(i * 37 + 11);
         ref_mem[i] = ram_mem[i];
      end
      ram_mem[4] = 8'h8C; ram_mem[5] = 8'h22; ram_mem[6] = 8'h00; ram_mem[7] = 8'h04;
      for (int i = 4; i < 8; i++) ref_mem[i] = ram_mem[i];

      reset = 1'b1; if_req = 1'b0; if_addr = '0;
      dm_req = 1'b0; dm_we = 1'b0; dm_size = '0; dm_addr = '0; dm_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", 32'({ram_en, busy, if_gnt, dm_gnt, if_done, dm_done, if_err, dm_err,
                           ram_we, ram_size}), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_ram_wdata", ram_wdata, 32'd0);
      @(negedge clk); reset = 1'b0;
      repeat (2) @(negedge clk);

      // Reset in the middle of a data load abandons it without a done pulse.
      dm_we = 1'b0; dm_size = SIZE_WORD; dm_addr = 9'h040; dm_req = 1'b1;
      @(negedge clk);
      chk("t1_ram_en_active", 32'(ram_en), 32'd1);
      reset = 1'b1; dm_req = 1'b0;
      #1;
      chk("t1_ctrl_zero", 32'({ram_en, busy, dm_gnt, dm_done, dm_err, ram_we, ram_size}), 32'd0);
      chk("t1_ram_addr_zero", 32'(ram_addr), 32'd0);
      @(negedge clk); reset = 1'b0;
      push_if(9'h010, 0);
      run_if();
      repeat (2) @(negedge clk);

      push_if(9'h004, 0);
      run_if();
      chk("t2_if_rdata", if_rdata, 32'h8C220004);
      repeat (2) @(negedge clk);

      // Simultaneous requests: data first, fetch right after data completes.
      gnt_log.delete();
      push_dm(1'b0, SIZE_WORD, 9'h044, '0, 0);
      push_if(9'h008, 0);
      fork run_dm(); run_if(); join
      chk("t3_first_is_dm", 32'(gnt_log.size() > 0 && gnt_log[0] == 1'b1), 32'd1);
      chk("t3_second_is_if", 32'(gnt_log.size() > 1 && gnt_log[1] == 1'b0), 32'd1);
      chk("t3_if_gnt_after_dm_done", 32'(if_gcyc - dm_dcyc), 32'd2);
      repeat (2) @(negedge clk);

      // Both held continuously: fetch is forced after every STARVE_MAX data grants.
      gnt_log.delete();
      for (int k = 0; k < 8; k++)
         push_dm(1'(k % 2), SIZE_WORD, 9'(9'h080 + 4 * k), $urandom, 0);
      push_if(9'h100, 0);
      push_if(9'h104, 0);
      fork run_dm(); run_if(); join
      chk("t4_grant_count", 32'(gnt_log.size()), 32'd10);
      for (int k = 0; k < 10 && k < int'(gnt_log.size()); k++)
         chk($sformatf("t4_grant%0d", k), 32'(gnt_log[k]),
             32'((k % (STARVE_MAX + 1)) != STARVE_MAX));
      repeat (2) @(negedge clk);

      push_dm(1'b1, SIZE_WORD, 9'h020, 32'h12345678, 0);
      push_dm(1'b0, SIZE_WORD, 9'h020, '0, 1);
      push_dm(1'b1, SIZE_BYTE, 9'h021, 32'h000000AB, 0);
      push_dm(1'b0, SIZE_WORD, 9'h020, '0, 2);
      run_dm();
      chk("t5_merged_word", dm_rdata, 32'h12AB5678);
      repeat (2) @(negedge clk);

      push_dm(1'b0, SIZE_HALF, 9'h003, '0, 0);
      push_dm(1'b0, SIZE_RSVD, 9'h000, '0, 1);
      run_dm();
      chk("t6_err_rdata", dm_rdata, 32'd0);
      repeat (2) @(negedge clk);

      // Random traffic: data in the low half of RAM, fetch in the high half.
      for (int k = 0; k < 40; k++)
         push_dm(1'($urandom), 2'($urandom), 9'($urandom_range(0, 255)), $urandom,
                 $urandom_range(0, 3));
      for (int k = 0; k < 30; k++)
         push_if(($urandom_range(0, 4) == 0) ? 9'(256 + $urandom_range(0, 255))
                                             : 9'((256 + $urandom_range(0, 255)) & 'h1FC),
                 $urandom_range(0, 3));
      fork run_dm(); run_if(); join
      repeat (5) @(negedge clk);
      chk("dm_queue_drained", 32'(dm_q.size()), 32'd0);
      chk("if_queue_drained", 32'(if_q.size()), 32'd0);
      chk("idle_at_end", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
